// File: rtl/card_datapath.sv
// card_datapath: baccarat datapath feeding the dealing state machine.
// Generates card ranks 1..13 and holds the six hand slots loaded by the
// state machine's strobes. Outputs the hand scores and slot count used by the
// state machine, and keeps saturating win/tie tallies from its win lights.
//
// Ports:
//   slow_clock                   clock, all state updates on posedge
//   resetb                       synchronous active-low reset
//   new_round                    clear all hand slots (tallies/generator kept)
//   load_pcard1..3/load_dcard1..3  load slot from new_card
//   player_win_light/dealer_win_light  win lights, rising edge = win
//   new_card                     current generator rank 1..13
//   pcard1..3/dcard1..3          slot contents, 0 = empty
//   pscore/dscore                hand scores 0..9 (combinational from slots)
//   cards_dealt                  occupied slot count 0..6 (combinational)
//   player_tally/dealer_tally/tie_tally  saturating outcome counters
//   round_done                   one-cycle pulse after any win-light rise
module card_datapath #(
    parameter int unsigned TALLY_W = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               new_round,
    input  logic               load_pcard1,
    input  logic               load_pcard2,
    input  logic               load_pcard3,
    input  logic               load_dcard1,
    input  logic               load_dcard2,
    input  logic               load_dcard3,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic [3:0]         new_card,
    output logic [3:0]         pcard1,
    output logic [3:0]         pcard2,
    output logic [3:0]         pcard3,
    output logic [3:0]         dcard1,
    output logic [3:0]         dcard2,
    output logic [3:0]         dcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic [2:0]         cards_dealt,
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally,
    output logic               round_done
);

    localparam int unsigned RANK_W   = 4;
    localparam int unsigned SLOTS    = 3;
    localparam logic [RANK_W-1:0]  RANK_MIN  = RANK_W'(1);
    localparam logic [RANK_W-1:0]  RANK_MAX  = RANK_W'(13);
    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    logic [RANK_W-1:0]  card_q, card_d;
    logic [RANK_W-1:0]  pcard_q [SLOTS];
    logic [RANK_W-1:0]  pcard_d [SLOTS];
    logic [RANK_W-1:0]  dcard_q [SLOTS];
    logic [RANK_W-1:0]  dcard_d [SLOTS];
    logic               pw_q, dw_q;
    logic [TALLY_W-1:0] ptally_q, ptally_d;
    logic [TALLY_W-1:0] dtally_q, dtally_d;
    logic [TALLY_W-1:0] ttally_q, ttally_d;
    logic               done_q, done_d;

    logic [SLOTS-1:0]   pload, dload;
    logic               p_rise, d_rise;

    assign pload  = {load_pcard3, load_pcard2, load_pcard1};
    assign dload  = {load_dcard3, load_dcard2, load_dcard1};
    assign p_rise = player_win_light & ~pw_q;
    assign d_rise = dealer_win_light & ~dw_q;

    // Baccarat value of one rank: face cards and tens count zero, empty slot is zero.
    function automatic logic [RANK_W-1:0] card_value(input logic [RANK_W-1:0] rank);
        return (rank >= RANK_W'(10)) ? RANK_W'(0) : rank;
    endfunction

    // Hand score = sum of three values mod 10; sum never exceeds 27.
    function automatic logic [RANK_W-1:0] hand_score(input logic [RANK_W-1:0] c1,
                                                     input logic [RANK_W-1:0] c2,
                                                     input logic [RANK_W-1:0] c3);
        logic [4:0] sum;
        sum = 5'(card_value(c1)) + 5'(card_value(c2)) + 5'(card_value(c3));
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return RANK_W'(sum);
    endfunction

    // Generator wraps 13 -> 1; any out-of-range value also recovers to 1.
    always_comb begin
        card_d = card_q + RANK_W'(1);
        if ((card_q >= RANK_MAX) || (card_q == '0)) begin
            card_d = RANK_MIN;
        end
    end

    // Slot next-state: new_round clears and beats any simultaneous load.
    always_comb begin
        for (int i = 0; i < int'(SLOTS); i++) begin
            pcard_d[i] = pcard_q[i];
            dcard_d[i] = dcard_q[i];
            if (new_round) begin
                pcard_d[i] = '0;
                dcard_d[i] = '0;
            end else begin
                if (pload[i]) pcard_d[i] = card_q;
                if (dload[i]) dcard_d[i] = card_q;
            end
        end
    end

    // Outcome tallies: simultaneous rises are a tie, otherwise one side wins.
    always_comb begin
        ptally_d = ptally_q;
        dtally_d = dtally_q;
        ttally_d = ttally_q;
        done_d   = p_rise | d_rise;
        if (p_rise && d_rise) begin
            if (ttally_q != TALLY_MAX) ttally_d = ttally_q + TALLY_ONE;
        end else if (p_rise) begin
            if (ptally_q != TALLY_MAX) ptally_d = ptally_q + TALLY_ONE;
        end else if (d_rise) begin
            if (dtally_q != TALLY_MAX) dtally_d = dtally_q + TALLY_ONE;
        end
    end

    // State registers.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            card_q   <= RANK_MIN;
            for (int i = 0; i < int'(SLOTS); i++) begin
                pcard_q[i] <= '0;
                dcard_q[i] <= '0;
            end
            pw_q     <= 1'b0;
            dw_q     <= 1'b0;
            ptally_q <= '0;
            dtally_q <= '0;
            ttally_q <= '0;
            done_q   <= 1'b0;
        end else begin
            card_q   <= card_d;
            for (int i = 0; i < int'(SLOTS); i++) begin
                pcard_q[i] <= pcard_d[i];
                dcard_q[i] <= dcard_d[i];
            end
            pw_q     <= player_win_light;
            dw_q     <= dealer_win_light;
            ptally_q <= ptally_d;
            dtally_q <= dtally_d;
            ttally_q <= ttally_d;
            done_q   <= done_d;
        end
    end

    // Occupied-slot count.
    always_comb begin
        cards_dealt = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            cards_dealt = cards_dealt + 3'(pcard_q[i] != '0) + 3'(dcard_q[i] != '0);
        end
    end

    assign pscore       = hand_score(pcard_q[0], pcard_q[1], pcard_q[2]);
    assign dscore       = hand_score(dcard_q[0], dcard_q[1], dcard_q[2]);

    assign new_card     = card_q;
    assign pcard1       = pcard_q[0];
    assign pcard2       = pcard_q[1];
    assign pcard3       = pcard_q[2];
    assign dcard1       = dcard_q[0];
    assign dcard2       = dcard_q[1];
    assign dcard3       = dcard_q[2];
    assign player_tally = ptally_q;
    assign dealer_tally = dtally_q;
    assign tie_tally    = ttally_q;
    assign round_done   = done_q;

endmodule

// File: tb/tb_card_datapath.sv
// Testbench for card_datapath: table of per-cycle vectors for reset, generator
// wrap, dealing and scoring, then hand-written sequences for tallies,
// saturation, new_round and reset in the middle of a round.
module tb_card_datapath;

    localparam int unsigned TALLY_W = 8;

    logic               slow_clock;
    logic               resetb;
    logic               new_round;
    logic               load_pcard1, load_pcard2, load_pcard3;
    logic               load_dcard1, load_dcard2, load_dcard3;
    logic               player_win_light, dealer_win_light;
    logic [3:0]         new_card;
    logic [3:0]         pcard1, pcard2, pcard3;
    logic [3:0]         dcard1, dcard2, dcard3;
    logic [3:0]         pscore, dscore;
    logic [2:0]         cards_dealt;
    logic [TALLY_W-1:0] player_tally, dealer_tally, tie_tally;
    logic               round_done;

    card_datapath #(.TALLY_W(TALLY_W)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .new_round        (new_round),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .new_card         (new_card),
        .pcard1           (pcard1),
        .pcard2           (pcard2),
        .pcard3           (pcard3),
        .dcard1           (dcard1),
        .dcard2           (dcard2),
        .dcard3           (dcard3),
        .pscore           (pscore),
        .dscore           (dscore),
        .cards_dealt      (cards_dealt),
        .player_tally     (player_tally),
        .dealer_tally     (dealer_tally),
        .tie_tally        (tie_tally),
        .round_done       (round_done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // One cycle: inputs applied before the edge, outputs expected after it.
    typedef struct packed {
        logic       rstb;
        logic       nr;
        logic [2:0] lp;
        logic [2:0] ld;
        logic       pl;
        logic       dl;
        logic [3:0] nc;
        logic [3:0] p1, p2, p3;
        logic [3:0] d1, d2, d3;
        logic [3:0] ps, ds;
        logic [2:0] dealt;
        logic       rd;
        logic [7:0] pt, dt, tt;
    } vec_t;

    vec_t vq[$];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        resetb           = v.rstb;
        new_round        = v.nr;
        load_pcard1      = v.lp[0];
        load_pcard2      = v.lp[1];
        load_pcard3      = v.lp[2];
        load_dcard1      = v.ld[0];
        load_dcard2      = v.ld[1];
        load_dcard3      = v.ld[2];
        player_win_light = v.pl;
        dealer_win_light = v.dl;
        @(posedge slow_clock);
        #1;
        chk({tag, ".new_card"},     int'(new_card),     int'(v.nc));
        chk({tag, ".pcard1"},       int'(pcard1),       int'(v.p1));
        chk({tag, ".pcard2"},       int'(pcard2),       int'(v.p2));
        chk({tag, ".pcard3"},       int'(pcard3),       int'(v.p3));
        chk({tag, ".dcard1"},       int'(dcard1),       int'(v.d1));
        chk({tag, ".dcard2"},       int'(dcard2),       int'(v.d2));
        chk({tag, ".dcard3"},       int'(dcard3),       int'(v.d3));
        chk({tag, ".pscore"},       int'(pscore),       int'(v.ps));
        chk({tag, ".dscore"},       int'(dscore),       int'(v.ds));
        chk({tag, ".cards_dealt"},  int'(cards_dealt),  int'(v.dealt));
        chk({tag, ".round_done"},   int'(round_done),   int'(v.rd));
        chk({tag, ".player_tally"}, int'(player_tally), int'(v.pt));
        chk({tag, ".dealer_tally"}, int'(dealer_tally), int'(v.dt));
        chk({tag, ".tie_tally"},    int'(tie_tally),    int'(v.tt));
    endtask

    // Append current expectation to the table, then drop one-shot strobes.
    task automatic add();
        vq.push_back(cur);
        cur.lp = '0;
        cur.ld = '0;
        cur.nr = 1'b0;
    endtask

    // Hand-sequence cycle: generator advances 1..13 with wrap.
    task automatic hstep(input string tag);
        cur.nc = (cur.nc == 4'd13) ? 4'd1 : cur.nc + 4'd1;
        run(tag, cur);
        cur.lp = '0;
        cur.ld = '0;
        cur.nr = 1'b0;
        cur.rd = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; new_round = 1'b0;
        load_pcard1 = 1'b0; load_pcard2 = 1'b0; load_pcard3 = 1'b0;
        load_dcard1 = 1'b0; load_dcard2 = 1'b0; load_dcard3 = 1'b0;
        player_win_light = 1'b0; dealer_win_light = 1'b0;

        // Reset held two cycles with loads and lights toggling.
        cur = '0;
        cur.nc = 4'd1; cur.lp = 3'b001; cur.pl = 1'b1; add();
        cur.pl = 1'b0; cur.ld = 3'b001; cur.dl = 1'b1; add();
        cur.dl = 1'b0; cur.rstb = 1'b1;
        // Generator 2..13 then wrap to 1.
        for (int k = 2; k <= 13; k++) begin cur.nc = 4'(k); add(); end
        cur.nc = 4'd1; add();
        for (int k = 2; k <= 7; k++) begin cur.nc = 4'(k); add(); end
        // Deal: pcard1@7, dcard1@8, pcard2@9.
        cur.lp = 3'b001; cur.p1 = 4'd7; cur.ps = 4'd7; cur.dealt = 3'd1; cur.nc = 4'd8; add();
        cur.ld = 3'b001; cur.d1 = 4'd8; cur.ds = 4'd8; cur.dealt = 3'd2; cur.nc = 4'd9; add();
        cur.lp = 3'b010; cur.p2 = 4'd9; cur.ps = 4'd6; cur.dealt = 3'd3; cur.nc = 4'd10; add();
        // Face cards and tens: player ends as 12,10,13.
        cur.lp = 3'b010; cur.p2 = 4'd10; cur.ps = 4'd7; cur.nc = 4'd11; add();
        cur.lp = 3'b100; cur.p3 = 4'd11; cur.ps = 4'd7; cur.dealt = 3'd4; cur.nc = 4'd12; add();
        cur.lp = 3'b001; cur.p1 = 4'd12; cur.ps = 4'd0; cur.nc = 4'd13; add();
        cur.lp = 3'b100; cur.p3 = 4'd13; cur.ps = 4'd0; cur.nc = 4'd1; add();
        for (int k = 2; k <= 9; k++) begin cur.nc = 4'(k); add(); end
        // Three dealer strobes at once, all load 9 -> 27 mod 10 = 7.
        cur.ld = 3'b111; cur.d1 = 4'd9; cur.d2 = 4'd9; cur.d3 = 4'd9;
        cur.ds = 4'd7; cur.dealt = 3'd6; cur.nc = 4'd10; add();
        for (int k = 11; k <= 13; k++) begin cur.nc = 4'(k); add(); end
        for (int k = 1; k <= 4; k++) begin cur.nc = 4'(k); add(); end
        // Overwrite occupied pcard1 with 4: count unchanged.
        cur.lp = 3'b001; cur.p1 = 4'd4; cur.ps = 4'd4; cur.nc = 4'd5; add();

        for (int i = 0; i < vq.size(); i++) begin
            run($sformatf("vec%0d", i), vq[i]);
        end
        cur = vq[vq.size() - 1];
        cur.lp = '0; cur.ld = '0; cur.nr = 1'b0;

        // Player rise, then held high: one count, one pulse.
        cur.pl = 1'b1; cur.pt = 8'd1; cur.rd = 1'b1; hstep("p_rise");
        for (int k = 0; k < 4; k++) hstep($sformatf("p_hold%0d", k));
        cur.pl = 1'b0; hstep("p_fall");
        // Both rise together: tie.
        cur.pl = 1'b1; cur.dl = 1'b1; cur.tt = 8'd1; cur.rd = 1'b1; hstep("tie");
        cur.pl = 1'b0; cur.dl = 1'b0; hstep("tie_fall");
        // Rises in different cycles: two separate wins.
        cur.dl = 1'b1; cur.dt = 8'd1; cur.rd = 1'b1; hstep("d_rise");
        cur.pl = 1'b1; cur.pt = 8'd2; cur.rd = 1'b1; hstep("p_rise_late");
        cur.pl = 1'b0; cur.dl = 1'b0; hstep("both_fall");
        // 300 more player wins saturate at 255.
        for (int i = 0; i < 300; i++) begin
            cur.pl = 1'b1;
            cur.pt = (cur.pt == 8'hFF) ? 8'hFF : cur.pt + 8'd1;
            cur.rd = 1'b1;
            hstep($sformatf("sat_hi%0d", i));
            cur.pl = 1'b0;
            hstep($sformatf("sat_lo%0d", i));
        end
        chk("sat_final", int'(player_tally), 255);

        // new_round beats load_dcard2; a dealer rise that cycle still counts.
        cur.nr = 1'b1; cur.ld = 3'b010; cur.dl = 1'b1;
        cur.p1 = '0; cur.p2 = '0; cur.p3 = '0;
        cur.d1 = '0; cur.d2 = '0; cur.d3 = '0;
        cur.ps = '0; cur.ds = '0; cur.dealt = '0;
        cur.dt = 8'd2; cur.rd = 1'b1; hstep("new_round");
        cur.dl = 1'b0; hstep("after_new_round");

        // Reset during a load and a rise: both discarded.
        cur.rstb = 1'b0; cur.lp = 3'b001; cur.pl = 1'b1;
        cur.nc = 4'd1; cur.pt = '0; cur.dt = '0; cur.tt = '0; cur.rd = 1'b0;
        run("rst_mid", cur);
        cur.lp = '0;
        cur.rstb = 1'b1; cur.pl = 1'b0; hstep("rst_release");
        cur.ld = 3'b001; cur.d1 = 4'd2; cur.ds = 4'd2; cur.dealt = 3'd1; hstep("load_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
